prime_div3_seq: RTL and testbench
=================================

Name: prime_div3_seq

Overview:
Sequential, width-parametrised classifier for unsigned integers. It returns p (operand is prime) and d (operand is a nonzero multiple of 3) using the same truth definition as the 4-bit combinational classifier.
- d: bit-serial mod-3 state machine.
- p: trial division with a restoring shift-subtract divider, one quotient bit per clock.
- Valid/ready handshakes on input and output. One operand in flight at a time.

Parameters:
WIDTH, 4, operand width in bits; legal range 2..16.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; forces IDLE
in_valid  input  1  operand offered on a
in_ready  output  1  block can accept an operand (high only in IDLE)
a  input  WIDTH  unsigned operand, sampled only on the accept edge
out_valid  output  1  p/d valid (high only in DONE)
out_ready  input  1  consumer accepts result
p  output  1  1 iff latched operand is prime
d  output  1  1 iff latched operand mod 3 == 0 and operand != 0

Behaviour:
- Reset (async, any state): state=IDLE, out_valid=0, p=0, d=0, internal n/k/remainder/counters cleared. in_ready=1 while reset is held and after release.
- in_ready and out_valid are decoded from the state register only; no combinational path from in_valid or out_ready.
- Accept edge: in_valid & in_ready. Latch a into n. Set mod-3 residue r3=0 and bit index=WIDTH-1. Go to MOD3. Later changes on a are ignored.
- MOD3: WIDTH cycles, MSB first: r3 <= (2*r3 + n[idx]) mod 3 (2-bit residue).
  - On the last MOD3 edge, register d = (r3_next==0) && (n!=0).
  - Same edge: if n<2, p=0 -> DONE. If n is 2 or 3, p=1 -> DONE. Otherwise k=2 -> CHECK.
- CHECK: 1 cycle.
  - k*k is evaluated at 2*WIDTH bits with no overflow.
  - If k*k > n: p=1 -> DONE. Else start the divider (remainder=0, count=WIDTH) -> DIVIDE.
- DIVIDE: WIDTH cycles of restoring division of n by k, remainder only.
  - Each cycle: rem = {rem, next MSB of n}; if rem >= k, rem -= k.
  - Remainder register is WIDTH+1 bits.
  - On the last edge: if final remainder==0, p=0 -> DONE. Else k <= (k==2) ? 3 : k+2 -> CHECK.
- DONE: out_valid=1; p and d held stable.
  - On out_ready=1: -> IDLE, out_valid drops the next cycle and in_ready rises on that same edge.
  - in_valid is ignored in DONE: no accept, no overwrite.
- Latency, counted in edges from the accept edge to out_valid high:
  - n<4: WIDTH.
  - Otherwise: WIDTH + t*(1+WIDTH) + (1 if terminated in CHECK), where t = number of divisors tried.
- Throughput: minimum 1 idle cycle between a DONE handshake and the next accept.
- Boundary values:
  - a=0: p=0, d=0.
  - a=1: p=0, d=0.
  - a=2^WIDTH-1 is handled; the k increment never overflows because CHECK terminates first.
- Simultaneous events:
  - reset dominates everything.
  - out_ready asserted in non-DONE states has no effect.
- Reset mid-operation (MOD3/CHECK/DIVIDE/DONE): the result is discarded and no out_valid pulse is produced.

Test Plan:
1. WIDTH=4, exhaustive a=0..15 with out_ready=1 -> p=1 exactly for {2,3,5,7,11,13}; d=1 exactly for {3,6,9,12,15}; all other values give p=0, d=0.
2. WIDTH=4 latency:
   - a=3: out_valid high exactly 4 edges after accept.
   - a=4: 9 edges (MOD3 4 + CHECK 1 + DIVIDE 4, remainder 0).
   - a=5: 10 edges (4 + CHECK + 4 + CHECK with 9>5).
3. Backpressure, WIDTH=4, a=9:
   - Hold out_ready=0 for 6 cycles -> out_valid stays 1, p=0, d=1 stable, in_ready=0.
   - During this, in_valid=1 with a=7 -> not accepted.
   - Release out_ready -> the next accepted operand is processed normally.
4. WIDTH=8:
   - a=251 -> p=1, d=0.
   - a=255 -> p=0, d=1.
   - a=221 (13*17) -> p=0, d=0.
   - a=2 -> p=1, d=0.
   - a=0 -> p=0, d=0.
5. Async reset mid-DIVIDE, WIDTH=8, a=251, reset pulsed between clock edges -> out_valid=0, p=0, d=0, in_ready=1 immediately without a clock edge. Follow with a=7 -> p=1, d=0.
6. Back-to-back, WIDTH=4: in_valid and out_ready held high, stream 11, 12, 13 -> results (1,0), (0,1), (1,0) in order. Each accept occurs exactly 1 cycle after the previous DONE handshake.

Source files
------------

// File: rtl/prime_div3_seq.sv
`default_nettype none
// ============================================================================
// Module   : prime_div3_seq
// Purpose  : Sequential classifier: p = operand is prime, d = nonzero multiple
//            of 3. Bit-serial mod-3 residue, then trial division by a
//            restoring shift-subtract divider (one quotient bit per clock).
// Revision : 1.0  initial release
// ============================================================================
module prime_div3_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             p,
    output logic             d
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MOD3   = 3'd1,
        S_CHECK  = 3'd2,
        S_DIVIDE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t               r_state, w_state_next;
    logic [WIDTH-1:0]     r_n, w_n_next;
    logic [WIDTH-1:0]     r_sh, w_sh_next;      // MSB-first bit stream of n
    logic [WIDTH-1:0]     r_k, w_k_next;
    logic [WIDTH:0]       r_rem, w_rem_next;
    logic [1:0]           r_r3, w_r3_next;
    logic [c_CNT_W-1:0]   r_cnt, w_cnt_next;
    logic                 r_p, w_p_next;
    logic                 r_d, w_d_next;

    logic                 w_bit;
    logic                 w_last;
    logic [2:0]           w_r3_sum;
    logic [1:0]           w_r3_step;
    logic [2*WIDTH-1:0]   w_kk;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_rem_step;
    logic [WIDTH-1:0]     w_k_inc;

    assign w_bit  = r_sh[WIDTH-1];
    assign w_last = (r_cnt == c_CNT_W'(1));

    // 2*r3 + bit is at most 5, so one conditional subtract reduces it mod 3
    assign w_r3_sum  = {r_r3, 1'b0} + {2'b00, w_bit};
    assign w_r3_step = (w_r3_sum >= 3'd3) ? 2'(w_r3_sum - 3'd3) : w_r3_sum[1:0];

    assign w_kk = {{WIDTH{1'b0}}, r_k} * {{WIDTH{1'b0}}, r_k};

    assign w_rem_sh   = (r_rem << 1) | {{WIDTH{1'b0}}, w_bit};
    assign w_rem_step = (w_rem_sh >= {1'b0, r_k}) ? (w_rem_sh - {1'b0, r_k}) : w_rem_sh;

    assign w_k_inc = (r_k == WIDTH'(2)) ? WIDTH'(3) : (r_k + WIDTH'(2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_sh    <= '0;
            r_k     <= '0;
            r_rem   <= '0;
            r_r3    <= '0;
            r_cnt   <= '0;
            r_p     <= 1'b0;
            r_d     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_n     <= w_n_next;
            r_sh    <= w_sh_next;
            r_k     <= w_k_next;
            r_rem   <= w_rem_next;
            r_r3    <= w_r3_next;
            r_cnt   <= w_cnt_next;
            r_p     <= w_p_next;
            r_d     <= w_d_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_n_next     = r_n;
        w_sh_next    = r_sh;
        w_k_next     = r_k;
        w_rem_next   = r_rem;
        w_r3_next    = r_r3;
        w_cnt_next   = r_cnt;
        w_p_next     = r_p;
        w_d_next     = r_d;

        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_n_next     = a;
                    w_sh_next    = a;
                    w_r3_next    = 2'd0;
                    w_cnt_next   = c_CNT_W'(WIDTH);
                    w_state_next = S_MOD3;
                end
            end
            S_MOD3: begin
                w_sh_next  = r_sh << 1;
                w_r3_next  = w_r3_step;
                w_cnt_next = r_cnt - c_CNT_W'(1);
                if (w_last) begin
                    w_d_next = (w_r3_step == 2'd0) && (r_n != '0);
                    if ((r_n >> 1) == '0) begin
                        w_p_next     = 1'b0;
                        w_state_next = S_DONE;
                    end else if ((r_n >> 2) == '0) begin
                        w_p_next     = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_k_next     = WIDTH'(2);
                        w_state_next = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (w_kk > {{WIDTH{1'b0}}, r_n}) begin
                    w_p_next     = 1'b1;
                    w_state_next = S_DONE;
                end else begin
                    w_rem_next   = '0;
                    w_sh_next    = r_n;
                    w_cnt_next   = c_CNT_W'(WIDTH);
                    w_state_next = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                w_sh_next  = r_sh << 1;
                w_rem_next = w_rem_step;
                w_cnt_next = r_cnt - c_CNT_W'(1);
                if (w_last) begin
                    if (w_rem_step == '0) begin
                        w_p_next     = 1'b0;
                        w_state_next = S_DONE;
                    end else begin
                        w_k_next     = w_k_inc;
                        w_state_next = S_CHECK;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign p         = r_p;
    assign d         = r_d;

endmodule
`default_nettype wire

// File: tb/tb_prime_div3_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_prime_div3_seq
// Purpose  : Self-checking bench for prime_div3_seq at WIDTH=4 and WIDTH=8
//            against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_prime_div3_seq;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       iv4 = 1'b0, ir4, ov4, ordy4 = 1'b0, p4, d4;
    logic [3:0] a4 = '0;
    logic       iv8 = 1'b0, ir8, ov8, ordy8 = 1'b0, p8, d8;
    logic [7:0] a8 = '0;

    int n_checks = 0;
    int n_errors = 0;

    prime_div3_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .a(a4),
        .out_valid(ov4), .out_ready(ordy4), .p(p4), .d(d4)
    );

    prime_div3_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .a(a8),
        .out_valid(ov8), .out_ready(ordy8), .p(p8), .d(d8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic from the classification rules
    function automatic int ref_prime(input int v);
        if (v < 2) return 0;
        for (int k = 2; k * k <= v; k++)
            if (v % k == 0) return 0;
        return 1;
    endfunction

    function automatic int ref_div3(input int v);
        return (v != 0 && v % 3 == 0) ? 1 : 0;
    endfunction

    function automatic int ref_lat(input int v, input int w);
        int t;
        int k;
        if (v < 4) return w;
        t = 0;
        k = 2;
        for (int it = 0; it < 1000; it++) begin
            if (k * k > v) return w + t * (1 + w) + 1;
            t++;
            if (v % k == 0) return w + t * (1 + w);
            k = (k == 2) ? 3 : k + 2;
        end
        return -1;
    endfunction

    task automatic drive_in(input int s, input logic v, input int val);
        if (s == 0) begin iv4 = v; a4 = val[3:0]; end
        else        begin iv8 = v; a8 = val[7:0]; end
    endtask

    task automatic drive_ordy(input int s, input logic v);
        if (s == 0) ordy4 = v; else ordy8 = v;
    endtask

    function automatic logic [31:0] rd_ir(input int s); return {31'b0, (s == 0) ? ir4 : ir8}; endfunction
    function automatic logic [31:0] rd_ov(input int s); return {31'b0, (s == 0) ? ov4 : ov8}; endfunction
    function automatic logic [31:0] rd_p (input int s); return {31'b0, (s == 0) ? p4  : p8 }; endfunction
    function automatic logic [31:0] rd_d (input int s); return {31'b0, (s == 0) ? d4  : d8 }; endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for out_valid, returning edges counted since the call
    task automatic wait_ov(input int s, output int lat);
        lat = 0;
        while (rd_ov(s) != 1 && lat < 2000) begin
            tick();
            lat++;
        end
    endtask

    // One full transaction: offer, accept, wait result, optional backpressure, handshake
    task automatic do_op(input int s, input int val, input int hold);
        int w;
        int lat;
        int budget;
        w = (s == 0) ? 4 : 8;
        drive_in(s, 1'b1, val);
        budget = 0;
        while (rd_ir(s) != 1 && budget < 50) begin
            tick();
            budget++;
        end
        check($sformatf("ready_w%0d_a%0d", w, val), rd_ir(s), 1);
        tick();
        drive_in(s, 1'b0, int'($urandom));
        wait_ov(s, lat);
        check($sformatf("lat_w%0d_a%0d", w, val), lat, ref_lat(val, w));
        check($sformatf("p_w%0d_a%0d", w, val), rd_p(s), ref_prime(val));
        check($sformatf("d_w%0d_a%0d", w, val), rd_d(s), ref_div3(val));
        for (int h = 0; h < hold; h++) begin
            drive_in(s, 1'b1, int'($urandom));
            tick();
            check($sformatf("hold_ov_a%0d", val), rd_ov(s), 1);
            check($sformatf("hold_ir_a%0d", val), rd_ir(s), 0);
            check($sformatf("hold_p_a%0d", val), rd_p(s), ref_prime(val));
            check($sformatf("hold_d_a%0d", val), rd_d(s), ref_div3(val));
        end
        drive_in(s, 1'b0, 0);
        drive_ordy(s, 1'b1);
        tick();
        drive_ordy(s, 1'b0);
        check($sformatf("hs_ov_a%0d", val), rd_ov(s), 0);
        check($sformatf("hs_ir_a%0d", val), rd_ir(s), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int vals[3];

        // Reset behaviour while held, before any clock edge
        #1 reset = 1'b1;
        #2;
        check("rst_ir4", rd_ir(0), 1);
        check("rst_ov4", rd_ov(0), 0);
        check("rst_p4", rd_p(0), 0);
        check("rst_d4", rd_d(0), 0);
        check("rst_ir8", rd_ir(1), 1);
        check("rst_ov8", rd_ov(1), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // Exhaustive WIDTH=4 (includes latency cases 3, 4, 5)
        for (int v = 0; v < 16; v++) do_op(0, v, 0);

        // Backpressure on a=9, then a normal follow-up operand
        do_op(0, 9, 6);
        do_op(0, 7, 0);

        // WIDTH=8 directed boundaries
        do_op(1, 251, 0);
        do_op(1, 255, 0);
        do_op(1, 221, 0);
        do_op(1, 2, 0);
        do_op(1, 0, 0);
        do_op(1, 1, 0);

        // Async reset mid-DIVIDE
        drive_in(1, 1'b1, 251);
        tick();
        drive_in(1, 1'b0, 0);
        repeat (12) tick();
        check("mid_ov", rd_ov(1), 0);
        #2 reset = 1'b1;
        #1;
        check("arst_ov", rd_ov(1), 0);
        check("arst_ir", rd_ir(1), 1);
        check("arst_p", rd_p(1), 0);
        check("arst_d", rd_d(1), 0);
        #1 reset = 1'b0;
        tick();

        // Async reset in DONE with p=1 discards the result
        drive_in(1, 1'b1, 7);
        tick();
        drive_in(1, 1'b0, 0);
        wait_ov(1, lat);
        check("done7_p", rd_p(1), 1);
        #2 reset = 1'b1;
        #1;
        check("arst_done_ov", rd_ov(1), 0);
        check("arst_done_p", rd_p(1), 0);
        check("arst_done_ir", rd_ir(1), 1);
        #1 reset = 1'b0;
        tick();
        check("post_rst_ov", rd_ov(1), 0);
        do_op(1, 7, 0);

        // Back-to-back stream with in_valid and out_ready held high
        vals = '{11, 12, 13};
        drive_ordy(0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive_in(0, 1'b1, vals[i]);
            tick();
            check($sformatf("b2b_acc_%0d", vals[i]), rd_ir(0), 0);
            wait_ov(0, lat);
            check($sformatf("b2b_lat_%0d", vals[i]), lat, ref_lat(vals[i], 4));
            check($sformatf("b2b_p_%0d", vals[i]), rd_p(0), ref_prime(vals[i]));
            check($sformatf("b2b_d_%0d", vals[i]), rd_d(0), ref_div3(vals[i]));
            tick();
            check($sformatf("b2b_hs_ir_%0d", vals[i]), rd_ir(0), 1);
        end
        drive_in(0, 1'b0, 0);
        drive_ordy(0, 1'b0);
        tick();
        check("b2b_idle", rd_ir(0), 1);

        // Randomized operands and backpressure
        for (int i = 0; i < 40; i++)
            do_op(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
        for (int i = 0; i < 10; i++)
            do_op(0, int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
